// File: rtl/simple_responder.sv
// simple_responder: target-side handshake BFM with programmable ack wait and a FWFT FIFO read port
module simple_responder #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int DLY_W      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_i,
    input  logic [DATA_WIDTH-1:0]        data_i,
    output logic                         ack_o,
    input  logic [DLY_W-1:0]             delay_i,
    output logic                         rd_valid_o,
    output logic [DATA_WIDTH-1:0]        rd_data_o,
    input  logic                         rd_ready_i,
    output logic [$clog2(DEPTH):0]       count_o,
    output logic [31:0]                  xfer_count_o,
    output logic                         err_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
    state_t                state;
    logic [DLY_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] cap;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic                  push, pop, full;
    logic [CW-1:0]         count_nx;
    assign push       = req_i && ack_o;
    assign pop        = rd_valid_o && rd_ready_i;
    assign full       = count_o == CW'(DEPTH);
    assign count_nx   = count_o + CW'(push) - CW'(pop);
    assign rd_valid_o = count_o != '0;
    assign rd_data_o  = mem[rd_ptr];
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= data_i;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ack_o        <= 1'b0;
            cnt          <= '0;
            cap          <= '0;
            err_o        <= 1'b0;
            count_o      <= '0;
            xfer_count_o <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
        end else begin
            count_o <= count_nx;
            if (push) begin
                wr_ptr       <= wr_ptr + 1'b1;
                xfer_count_o <= xfer_count_o + 32'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case (state)
                IDLE: if (req_i) begin
                    cap <= data_i;
                    if (delay_i == '0 && !full) begin
                        state <= ACK;
                        ack_o <= 1'b1;
                    end else begin
                        state <= WAIT;
                        cnt   <= delay_i == '0 ? '0 : delay_i - 1'b1;
                    end
                end
                WAIT: if (!req_i) begin
                    state <= IDLE;
                    err_o <= 1'b1;
                end else begin
                    if (data_i != cap) err_o <= 1'b1;
                    if (cnt != '0) cnt <= cnt - 1'b1;
                    else if (!full) begin
                        state <= ACK;
                        ack_o <= 1'b1;
                    end
                end
                ACK: if (!req_i || delay_i != '0 || count_nx >= CW'(DEPTH)) begin
                    state <= IDLE;
                    ack_o <= 1'b0;
                end else cap <= data_i;  // streaming: the next word becomes the reference
                default: begin
                    state <= IDLE;
                    ack_o <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_simple_responder.sv
// tb_simple_responder: random initiator/host traffic against a queue-based scoreboard of simple_responder
module tb_simple_responder;
    localparam int DEPTH = 4;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [7:0]  data = '0;
    logic        ack_o;
    logic [3:0]  delay = '0;
    logic        rd_valid_o;
    logic [7:0]  rd_data_o;
    logic        rd_ready = 1'b0;
    logic [2:0]  count_o;
    logic [31:0] xfer_count_o;
    logic        err_o;
    int          checks = 0;
    int          errors = 0;
    logic        mon_en = 1'b0;
    logic        rnd_on = 1'b0;
    logic [7:0]  exp_q [$];
    int          xfer_exp = 0;

    simple_responder #(.DATA_WIDTH(8), .DEPTH(DEPTH), .DLY_W(4)) dut (
        .clk(clk), .rst(rst), .req_i(req), .data_i(data), .ack_o(ack_o), .delay_i(delay),
        .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o), .rd_ready_i(rd_ready),
        .count_o(count_o), .xfer_count_o(xfer_count_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: words accepted on req&&ack must reappear in order on the read port
    always @(negedge clk) if (mon_en) begin
        chk("count", 32'(count_o), exp_q.size());
        chk("valid", 32'(rd_valid_o), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) chk("head", 32'(rd_data_o), 32'(exp_q[0]));
        chk("xfers", xfer_count_o, xfer_exp);
        chk("ack_full", 32'(ack_o && exp_q.size() == DEPTH), 0);
        if (rd_ready && exp_q.size() != 0) void'(exp_q.pop_front());
        if (req && ack_o) begin
            exp_q.push_back(data);
            xfer_exp++;
        end
    end

    task automatic do_reset();
        mon_en = 1'b0;
        req = 1'b0;
        rd_ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
        xfer_exp = 0;
        mon_en = 1'b1;
    endtask

    // Holds req for n transfers; word k carries base+k; lat = cycles from req to first ack
    task automatic burst(input int n, input int d, input int dmax, input logic [7:0] base, output int lat);
        int got = 0;
        int cyc = 0;
        logic x;
        lat = -1;
        req = 1'b1;
        delay = 4'(d);
        data = base;
        while (got < n && cyc < 400) begin
            x = ack_o;
            tick();
            cyc++;
            if (lat < 0 && ack_o) lat = cyc;
            if (x) begin
                got++;
                data = base + 8'(got);
                delay = 4'($urandom_range(0, dmax));
            end
        end
        if (got < n) chk("burst_timeout", got, n);
        req = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int lat, w, d;
        logic x;
        #1;
        chk("rst_ack", 32'(ack_o), 0);
        chk("rst_valid", 32'(rd_valid_o), 0);
        chk("rst_count", 32'(count_o), 0);
        do_reset();
        chk("rst_xfer", xfer_count_o, 0);
        chk("rst_err", 32'(err_o), 0);

        req = 1'b1; delay = 4'd0; data = 8'h5A;
        tick();
        chk("d0_ack", 32'(ack_o), 1);
        tick();
        req = 1'b0;
        chk("d0_data", 32'(rd_data_o), 32'h5A);
        chk("d0_count", 32'(count_o), 1);
        chk("d0_xfer", xfer_count_o, 1);
        tick();
        rd_ready = 1'b1;
        tick();
        tick();

        burst(1, 3, 0, 8'h33, lat);
        chk("lat_d3", lat, 4);
        chk("lat_d3_err", 32'(err_o), 0);
        for (int i = 0; i < 8; i++) begin
            d = $urandom_range(0, 15);
            burst(1, d, 0, 8'($urandom), lat);
            chk("lat_rand", lat, d + 1);
        end
        chk("lat_err", 32'(err_o), 0);

        do_reset();
        req = 1'b1; delay = 4'd0; data = 8'd1; w = 1;
        repeat (12) begin
            x = ack_o;
            tick();
            if (x) begin w++; data = 8'(w); end
        end
        chk("full_xfers", w - 1, 4);
        chk("full_ack", 32'(ack_o), 0);
        chk("full_count", 32'(count_o), 4);
        chk("full_head", 32'(rd_data_o), 1);
        rd_ready = 1'b1;
        for (int c = 0; c < 40 && w <= 6; c++) begin
            x = ack_o;
            tick();
            if (x) begin w++; data = 8'(w); end
        end
        req = 1'b0;
        repeat (8) tick();
        chk("full_resume", w - 1, 6);
        chk("full_drain", 32'(count_o), 0);
        chk("full_err", 32'(err_o), 0);

        rnd_on = 1'b1;
        fork
            while (rnd_on) begin
                tick();
                rd_ready = 1'($urandom_range(0, 1));
            end
        join_none
        for (int i = 0; i < 30; i++)
            burst($urandom_range(1, 6), $urandom_range(0, 3), $urandom_range(0, 1), 8'($urandom), lat);
        rnd_on = 1'b0;
        tick();
        tick();
        rd_ready = 1'b1;
        repeat (8) tick();
        chk("rnd_drain", 32'(count_o), 0);
        chk("rnd_err", 32'(err_o), 0);

        do_reset();
        req = 1'b1; delay = 4'd5; data = 8'h11;
        tick(); tick();
        req = 1'b0;
        tick();
        chk("err_drop", 32'(err_o), 1);
        repeat (3) tick();
        chk("err_sticky", 32'(err_o), 1);
        do_reset();
        chk("err_clr", 32'(err_o), 0);
        req = 1'b1; delay = 4'd5; data = 8'h22;
        tick(); tick();
        data = 8'h23;
        tick();
        chk("err_data", 32'(err_o), 1);
        req = 1'b0;
        tick();

        do_reset();
        req = 1'b1; delay = 4'd0; data = 8'hA0; w = 0;
        for (int c = 0; c < 20 && w < 2; c++) begin
            x = ack_o;
            tick();
            if (x) begin w++; data = 8'hA0 + 8'(w); end
        end
        chk("ar_pre_ack", 32'(ack_o), 1);
        chk("ar_pre_count", 32'(count_o), 2);
        mon_en = 1'b0;
        req = 1'b0;
        rst = 1'b1;
        #1;
        chk("ar_ack", 32'(ack_o), 0);
        chk("ar_valid", 32'(rd_valid_o), 0);
        chk("ar_count", 32'(count_o), 0);
        chk("ar_xfer", xfer_count_o, 0);
        exp_q.delete();
        xfer_exp = 0;
        tick();
        rst = 1'b0;
        mon_en = 1'b1;
        burst(1, 2, 0, 8'hC3, lat);
        chk("ar_lat", lat, 3);
        chk("ar_next_xfer", xfer_count_o, 1);
        chk("ar_next_err", 32'(err_o), 0);
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/simple_responder.md
# simple_responder

Target-side BFM for the req/ack/data handshake driven by `simple_bfm` initiators. It accepts words from one initiator, drives `ack_o` with a programmable per-transfer wait, and buffers accepted words in a small first-word-fall-through FIFO. The host/testbench drains the FIFO through a valid/ready read port. It replaces the fixed "ack = req delayed one cycle" responder in unit-test tops, so initiator BFMs can be exercised against variable latency and backpressure.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: width of `data_i` and `rd_data_o`.
- `DEPTH`, default 4: FIFO depth; must be a power of two and at least 2.
- `DLY_W`, default 4: width of `delay_i`.

Ports:
- `clk`, in, 1: the single clock; all logic is on its rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `req_i`, in, 1: initiator request.
- `data_i`, in, DATA_WIDTH: initiator data; must be stable while `req_i`=1 until transfer.
- `ack_o`, out, 1: registered acknowledge.
- `delay_i`, in, DLY_W: wait cycles inserted before each acknowledge; sampled on the cycle a request is accepted.
- `rd_valid_o`, out, 1: FIFO not empty.
- `rd_data_o`, out, DATA_WIDTH: FIFO head word.
- `rd_ready_i`, in, 1: pop the FIFO when `rd_valid_o`=1.
- `count_o`, out, $clog2(DEPTH)+1: FIFO occupancy.
- `xfer_count_o`, out, 32: total completed transfers; wraps 0xFFFF_FFFF→0.
- `err_o`, out, 1: sticky protocol-error flag.

## Operation
- Transfer: any rising edge with `req_i`=1 and `ack_o`=1. On a transfer, `data_i` is pushed into the FIFO and `xfer_count_o` increments. A cycle with `ack_o`=1 and `req_i`=0 is not a transfer.
- FSM states: IDLE, WAIT, ACK. `ack_o`=1 only in ACK (Moore, registered).
- IDLE: when `req_i`=1, `delay_i` is sampled.
  - `delay_i`=0 and FIFO not full → ACK.
  - `delay_i`=0 and FIFO full → WAIT with cnt=0.
  - `delay_i`=d>0 → WAIT with cnt=d-1.
  - On entering WAIT or ACK, `data_i` is captured into `cap`.
- WAIT:
  - `req_i`=0 → IDLE and set `err_o` (request withdrawn before ack).
  - cnt≠0 → decrement cnt.
  - cnt=0 and FIFO not full → ACK.
  - cnt=0 and FIFO full → hold in WAIT.
- ACK:
  - `req_i`=0 → IDLE.
  - Transfer, `delay_i`=0, and post-push occupancy (including any same-cycle pop) < DEPTH → stay in ACK (back-to-back streaming).
  - Transfer otherwise → IDLE.
- Data check: in WAIT, or in ACK before the transfer edge, `req_i`=1 and `data_i`≠`cap` sets `err_o`. `cap` reloads after each transfer when the FSM stays in ACK.
- FIFO:
  - Pop when `rd_valid_o`&&`rd_ready_i`. `rd_data_o` is the head word, combinational from storage.
  - Simultaneous push and pop leaves `count_o` unchanged.
  - Pointers wrap modulo DEPTH.
  - A push never occurs when full, because `ack_o` is gated.
  - A pop when empty is ignored.
- Reset (asynchronous, any state, including mid-handshake) → IDLE, with:
  - `ack_o`=0, `rd_valid_o`=0, `count_o`=0, `xfer_count_o`=0, `err_o`=0;
  - cnt=0 and pointers=0.
  - FIFO contents are discarded; `rd_data_o` is don't-care.

## Timing
- Request seen at edge E0 with `delay_i`=d and FIFO space available:
  - `ack_o` rises after edge E(d);
  - the transfer happens at E(d+1);
  - for d=0, `ack_o` is high in the cycle after E0.
- Streaming with d=0: one transfer per cycle while `req_i` stays high and space remains.
- After `req_i` falls, `ack_o` stays high for one cycle, then drops.
- Pushed word: visible on `rd_valid_o`/`rd_data_o` the cycle after the transfer edge; push-to-read latency is 1.
- `count_o`, `xfer_count_o` and `err_o` update on the same edge as the event that changes them.

## Test plan
- Reset, then single request, `delay_i`=0, data 0x5A → `ack_o` high the cycle after req; one transfer; `rd_data_o`=0x5A; `count_o`=1; `xfer_count_o`=1.
- `delay_i`=3, req at E0 → `ack_o` first high after E3; transfer at E4; `err_o`=0.
- DEPTH=4, `rd_ready_i`=0, streaming 0x01..0x06 → 4 transfers; `ack_o` low while `count_o`=4. Then raise `rd_ready_i` → drain yields 0x01..0x04 in order, and transfers of 0x05 and 0x06 resume.
- Two initiators (two instances), continuous req, d=0, `rd_ready_i`=1 → one transfer per cycle each after the first; `count_o` stays ≤1; 100 words each, in order.
- Initiator drops `req_i` during WAIT (d=5), or changes `data_i` before ack → `err_o`=1 and stays 1 until `rst`.
- Assert `rst` while `ack_o`=1 with 2 words buffered → `ack_o`, `rd_valid_o`, `count_o` and `xfer_count_o` go to 0 without waiting for a clock edge; the next request completes normally.
